adder_result_checker: RTL
=========================

Name: adder_result_checker

Overview:
- Downstream consumer of the operand delay line in the fv auxiliary logic.
- Receives operands and carry-in already delayed by LATENCY cycles, computes the golden sum, and compares it against the adder DUT result arriving in the same cycle.
- Reports a registered mismatch pulse, a sticky error flag, saturating check and error counters, and a capture of the first failing pair.
- Used by formal properties ("err_sticky never rises") and by simulation benches.

Parameters:
- WIDTH, 8: operand and sum width in bits.
- LATENCY, 4: DUT pipeline latency in cycles. Equals the DELAY of the upstream operand delay line. Legal range 0..255.
- CNT_W, 16: width of check_count and err_count.

Ports:
- clk  input  1  single clock, rising edge.
- arst  input  1  asynchronous reset, active-high.
- en  input  1  checking enable. Upstream stimulus is valid while high.
- a_dly  input  WIDTH  operand A, delayed LATENCY cycles.
- b_dly  input  WIDTH  operand B, delayed LATENCY cycles.
- cin_dly  input  1  carry-in, delayed LATENCY cycles.
- sum  input  WIDTH  DUT sum.
- cout  input  1  DUT carry-out.
- armed  output  1  high while state is CHECK or FAIL.
- mismatch  output  1  one-cycle registered pulse per failing comparison.
- err_sticky  output  1  set on first mismatch; cleared only by arst.
- check_count  output  CNT_W  number of comparisons performed, saturating.
- err_count  output  CNT_W  number of mismatches, saturating.
- first_exp  output  WIDTH+1  expected {cout,sum} at the first mismatch.
- first_got  output  WIDTH+1  DUT {cout,sum} at the first mismatch.

Behaviour:
- Reset (arst high, asynchronous):
  - state=WARMUP, warm_cnt=0.
  - All outputs are 0: armed, mismatch, err_sticky, both counters, first_exp, first_got.
- Golden model: exp = a_dly + b_dly + cin_dly, computed at WIDTH+1 bits with zero extension, no truncation. got = {cout,sum}.
- warm_cnt: width sized to hold LATENCY. It counts consecutive cycles with en=1 while in WARMUP.
- States:
  - WARMUP:
    - en=1 and warm_cnt==LATENCY-1: go to CHECK.
    - en=1 otherwise: warm_cnt+1.
    - en=0: warm_cnt cleared to 0.
    - LATENCY=0: with en=1, go to CHECK on the first cycle and perform no comparison that cycle.
  - CHECK:
    - Each cycle with en=1 is a comparison cycle.
    - en=0: go to WARMUP and clear warm_cnt, because the pipeline contents are now stale. No comparison that cycle.
    - A comparison with exp!=got: go to FAIL.
  - FAIL:
    - Terminal until reset.
    - Comparisons continue on en=1 cycles.
    - en=0 does not leave FAIL but suspends comparisons.
- Comparison cycle (state CHECK or FAIL, en=1): sampled at the rising edge; results are visible one cycle later (latency 1).
  - check_count increments, holding at all-ones.
  - If exp!=got:
    - mismatch=1 in the next cycle.
    - err_count increments, saturating.
    - err_sticky=1.
    - If err_sticky was 0, first_exp and first_got are loaded. They never reload afterwards.
- Non-comparison cycle: mismatch=0; counters and captures hold.
- armed is a registered decode of state. It goes high the cycle after the WARMUP→CHECK transition edge.
- Simultaneous events:
  - A mismatch on the same cycle err_sticky first sets: both counters update and the capture loads, all in the same edge.
  - Counter saturation does not block the err_sticky update or the capture.
- Reset mid-operation: everything returns to reset values immediately, with no dependence on clk. The first comparison after release requires a full LATENCY-cycle warmup again.
- X on DUT inputs during WARMUP is ignored. No comparison is made and no output depends on those inputs.

Test Plan:
- Reset and warmup, WIDTH=8, LATENCY=4: release arst, hold en=1, correct DUT. armed rises after 4 en cycles; with a_dly=0xFF, b_dly=0x01, cin_dly=1, expected exp=0x101; check_count increments each cycle; err_sticky stays 0.
- Single fault: in CHECK, drive a_dly=0x12, b_dly=0x34, cin_dly=0, sum=0x47, cout=0. Next cycle mismatch=1, err_count=1, err_sticky=1, first_exp=0x046, first_got=0x047, state=FAIL.
- Second fault: sum=0x00 against expected 0x0FE. err_count=2, first_exp and first_got unchanged at 0x046 and 0x047, mismatch pulses again.
- en drop: deassert en for 1 cycle in CHECK. armed falls, no comparison is made on any en=0 cycle, and armed re-rises only after 4 more en=1 cycles. Repeat in FAIL: state stays FAIL.
- Saturation, CNT_W=4: 20 consecutive mismatching cycles give err_count=0xF and check_count=0xF, both held.
- Async reset mid-run plus LATENCY=0 config: pulse arst between clock edges in FAIL and check all outputs are 0 immediately. With LATENCY=0, armed rises one cycle after en=1 and the first comparison occurs on the next en cycle.

Source files
------------

// File: rtl/adder_result_checker.sv
// adder_result_checker
// Golden-model checker for a pipelined adder. Operands arrive already delayed
// by LATENCY cycles so they line up with the adder result in the same cycle.
// A warmup phase waits for the delay line to fill with valid data before any
// comparison is made; any en=0 cycle while checking invalidates the pipeline
// and forces a fresh warmup. Once a mismatch is seen the checker stays in FAIL
// until reset, still comparing on every en=1 cycle.
//
// Handshake: en behaves as a valid qualifier on the delayed operands and the
// adder result together; there is no backpressure (the checker is always
// ready), so every en=1 cycle outside warmup is consumed as one comparison.
module adder_result_checker #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_dly,
  input  logic [WIDTH-1:0] b_dly,
  input  logic             cin_dly,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             armed,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH:0]   first_exp,
  output logic [WIDTH:0]   first_got,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    CHECK  = 2'd1,
    FAIL   = 2'd2
  } state_t;

  // Warmup counter wide enough to hold LATENCY; at least one bit so the
  // LATENCY=0 and LATENCY=1 configurations still elaborate.
  localparam int WARM_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  // Last warmup count before arming. With LATENCY=0 the counter sits at zero,
  // so the first en=1 cycle already matches and arms without comparing.
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_t            state;
  state_t            state_next;
  logic [WARM_W-1:0] warm_cnt;
  logic [WARM_W-1:0] warm_next;

  logic [WIDTH:0] exp_sum;
  logic [WIDTH:0] got_sum;
  logic           cmp_cycle;
  logic           is_bad;

  // Golden sum at full WIDTH+1 precision; carry-out is the top bit.
  assign exp_sum = {1'b0, a_dly} + {1'b0, b_dly} + {{WIDTH{1'b0}}, cin_dly};
  assign got_sum = {cout, sum};

  // Inputs are only looked at on comparison cycles, so X during warmup is
  // masked by cmp_cycle before reaching any state.
  assign cmp_cycle = en && (state != WARMUP);
  assign is_bad    = cmp_cycle && (exp_sum != got_sum);

  assign state_dbg = state;

  // State and warmup counter registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= WARMUP;
      warm_cnt <= '0;
    end else begin
      state    <= state_next;
      warm_cnt <= warm_next;
    end
  end

  // Next-state logic: warmup counting, arming, en-drop handling, FAIL lock.
  always_comb begin
    state_next = state;
    warm_next  = warm_cnt;
    case (state)
      WARMUP: begin
        if (!en) begin
          warm_next = '0;
        end else if (warm_cnt == WARM_LAST) begin
          state_next = CHECK;
          warm_next  = '0;
        end else begin
          warm_next = warm_cnt + WARM_W'(1);
        end
      end
      CHECK: begin
        if (!en) begin
          // Pipeline contents are stale after a gap; refill before checking.
          state_next = WARMUP;
          warm_next  = '0;
        end else if (is_bad) begin
          state_next = FAIL;
        end
      end
      FAIL: begin
        state_next = FAIL;
      end
      default: begin
        state_next = WARMUP;
        warm_next  = '0;
      end
    endcase
  end

  // Registered reporting: armed decode, mismatch pulse, counters, captures.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      armed       <= 1'b0;
      mismatch    <= 1'b0;
      err_sticky  <= 1'b0;
      check_count <= '0;
      err_count   <= '0;
      first_exp   <= '0;
      first_got   <= '0;
    end else begin
      armed    <= (state_next != WARMUP);
      mismatch <= is_bad;
      if (cmp_cycle && (check_count != '1)) begin
        check_count <= check_count + CNT_W'(1);
      end
      if (is_bad) begin
        if (err_count != '1) begin
          err_count <= err_count + CNT_W'(1);
        end
        err_sticky <= 1'b1;
        // Only the first failing pair is kept for debug.
        if (!err_sticky) begin
          first_exp <= exp_sum;
          first_got <= got_sum;
        end
      end
    end
  end

endmodule
